// File: rtl/trigger_event_builder.sv
// trigger_event_builder
//   Frames TDS data words seen while the trigger gate is high into one event
//   per gate: a header word, up to MAX_WORDS data words, then a trailer word.
//   Events are queued in a first-word-fall-through FIFO. The FIFO drains over
//   a valid/ready stream.
//
//   Entry layout is {first, last, data[31:0]}.
//     header  : {8'hAA, trigger_index, 16'h0000}, first=1
//     trailer : {8'hEE, trunc, 7'b0, wcnt[15:0]}, last=1
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   trigger          trigger gate (level)
//   trigger_index    event index, captured into the header
//   data_in/valid    TDS data word and its qualifier
//   out_*            FWFT stream (out_valid = FIFO not empty)
//   fifo_level       registered FIFO occupancy
//   dropped_events   whole events rejected for lack of space (saturating)
//   busy             an event is being captured
module trigger_event_builder #(
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_WORDS  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          trigger,
  input  logic [7:0]                    trigger_index,
  input  logic [31:0]                   data_in,
  input  logic                          data_valid,
  output logic [31:0]                   out_data,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   dropped_events,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} state_t;

  state_t          state_q, state_d;
  logic            trig_dly_q, trig_dly_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic            trunc_q, trunc_d;
  logic [15:0]     drop_q, drop_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;

  logic [33:0]     mem [FIFO_DEPTH];

  logic            rise, push, pop, room;
  logic [LW-1:0]   free;
  logic [33:0]     push_word;

  assign rise = trigger & ~trig_dly_q;
  // Free space uses the registered level only; a pop in this cycle is not
  // credited, so the FIFO can never be overfilled.
  assign free = LW'(FIFO_DEPTH) - level_q;
  // Two free slots are needed for anything other than a trailer: the second
  // slot stays reserved so the closing trailer always fits.
  assign room = free >= LW'(2);

  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rptr_q][31:0] : '0;
  assign out_first = out_valid & mem[rptr_q][33];
  assign out_last  = out_valid & mem[rptr_q][32];

  assign fifo_level     = level_q;
  assign dropped_events = drop_q;
  assign busy           = (state_q == CAPTURE);

  // The header already carries the event index, so it is not held past the
  // rise cycle.
  always_comb begin
    state_d    = state_q;
    trig_dly_d = trigger;
    wcnt_d     = wcnt_q;
    trunc_d    = trunc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_word  = '0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          if (room) begin
            push      = 1'b1;
            push_word = {2'b10, 8'hAA, trigger_index, 16'h0000};
            wcnt_d    = '0;
            trunc_d   = 1'b0;
            state_d   = CAPTURE;
          end else begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            state_d = SKIP;
          end
        end
      end
      CAPTURE: begin
        if (!trigger) begin
          push      = 1'b1;
          push_word = {2'b01, 8'hEE, trunc_q, 7'b0, wcnt_q};
          state_d   = IDLE;
        end else if (data_valid) begin
          if (wcnt_q < MAXW && room) begin
            push      = 1'b1;
            push_word = {2'b00, data_in};
            wcnt_d    = wcnt_q + 16'd1;
          end else begin
            trunc_d = 1'b1;
          end
        end
      end
      SKIP: begin
        if (!trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // trig_dly resets high so a gate already high at reset release is not
  // mistaken for a new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      trig_dly_q <= 1'b1;
      wcnt_q     <= '0;
      trunc_q    <= 1'b0;
      drop_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      trig_dly_q <= trig_dly_d;
      wcnt_q     <= wcnt_d;
      trunc_q    <= trunc_d;
      drop_q     <= drop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
    end
  end

  // Storage carries no reset; the outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= push_word;
  end

endmodule

// File: tb/tb_trigger_event_builder.sv
module tb_trigger_event_builder;

  localparam int DEPTH = 8;
  localparam int MAXW  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk, rst_n, trigger, data_valid, out_ready;
  logic [7:0]    trigger_index;
  logic [31:0]   data_in, out_data;
  logic          out_first, out_last, out_valid, busy;
  logic [LW-1:0] fifo_level;
  logic [15:0]   dropped_events;

  int n_checks = 0;
  int n_err    = 0;

  trigger_event_builder #(.FIFO_DEPTH(DEPTH), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .trigger_index(trigger_index),
    .data_in(data_in), .data_valid(data_valid), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level),
    .dropped_events(dropped_events), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Stream words actually delivered by the DUT ({first,last,data}).
  logic [33:0] got[$];
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) got.push_back({out_first, out_last, out_data});

  // Reference model: the FIFO is a plain queue, events are framed from the
  // gate edges; exp collects the words the stream should deliver.
  logic [33:0] m_q[$];
  logic [33:0] exp_s[$];
  bit          m_trig;
  int          m_mode;   // 0 waiting, 1 in event, 2 skipping a rejected gate
  int          m_wcnt, m_drop;
  bit          m_trunc;

  task automatic model_reset();
    m_q.delete(); m_trig = 1; m_mode = 0; m_wcnt = 0; m_drop = 0; m_trunc = 0;
  endtask

  task automatic step(input bit t, input bit dv, input logic [31:0] d,
                      input logic [7:0] ix, input bit rdy);
    int free;
    bit do_push;
    logic [33:0] w;
    trigger = t; data_valid = dv; data_in = d; trigger_index = ix; out_ready = rdy;
    free = DEPTH - m_q.size();
    do_push = 0; w = '0;
    if (m_mode == 0) begin
      if (t && !m_trig) begin
        if (free >= 2) begin
          do_push = 1; w = {2'b10, 8'hAA, ix, 16'h0};
          m_wcnt = 0; m_trunc = 0; m_mode = 1;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_mode = 2;
        end
      end
    end else if (m_mode == 1) begin
      if (!t) begin
        do_push = 1; w = {2'b01, 8'hEE, m_trunc, 7'b0, 16'(m_wcnt)}; m_mode = 0;
      end else if (dv) begin
        if (m_wcnt < MAXW && free >= 2) begin do_push = 1; w = {2'b00, d}; m_wcnt++; end
        else m_trunc = 1;
      end
    end else if (!t) m_mode = 0;
    if (m_q.size() > 0 && rdy) exp_s.push_back(m_q.pop_front());
    if (do_push) m_q.push_back(w);
    m_trig = t;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if ({out_first, out_last, out_data} !== 34'h0) begin n_err++; $display("FAIL reset_data got %h want 0", {out_first, out_last, out_data}); end
    n_checks++; if (fifo_level !== '0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_checks++; if (dropped_events !== 16'h0) begin n_err++; $display("FAIL reset_dropped got %0d want 0", dropped_events); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] seq[5] = '{5, 1, 2, 3, 4};
    logic [33:0] ex[$];
    got.delete();
    step(0, 0, 0, 8'h07, 1);
    foreach (seq[i]) begin
      step(1, 1, seq[i], 8'h07, 1);
      if (i == 0) begin
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy); end
      end
    end
    step(0, 1, 32'h99, 8'h07, 1);
    repeat (3) step(0, 0, 0, 8'h07, 1);
    ex = '{{2'b10, 32'hAA070000}, {2'b00, 32'd1}, {2'b00, 32'd2}, {2'b00, 32'd3},
           {2'b00, 32'd4}, {2'b01, 32'hEE000004}};
    n_checks++;
    if (got.size() !== ex.size()) begin n_err++; $display("FAIL basic_len got %0d want %0d", got.size(), ex.size()); end
    else foreach (ex[i]) begin
      n_checks++; if (got[i] !== ex[i]) begin n_err++; $display("FAIL basic_word%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_trunc();
    logic [31:0] d[10];
    logic [33:0] ex[$];
    got.delete();
    foreach (d[i]) d[i] = $urandom;
    step(0, 0, 0, 8'h01, 1);
    foreach (d[i]) step(1, 1, d[i], 8'h01, 1);
    step(0, 0, 0, 8'h01, 1);
    repeat (3) step(0, 0, 0, 8'h01, 1);
    ex = '{{2'b10, 32'hAA010000}, {2'b00, d[1]}, {2'b00, d[2]}, {2'b00, d[3]},
           {2'b00, d[4]}, {2'b01, 32'hEE800004}};
    n_checks++;
    if (got.size() !== ex.size()) begin n_err++; $display("FAIL trunc_len got %0d want %0d", got.size(), ex.size()); end
    else foreach (ex[i]) begin
      n_checks++; if (got[i] !== ex[i]) begin n_err++; $display("FAIL trunc_word%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_full();
    logic [31:0] d[4];
    logic [33:0] ex[$];
    got.delete();
    foreach (d[i]) d[i] = $urandom;
    step(0, 0, 0, 8'h11, 0);
    step(1, 1, 32'h0, 8'h11, 0);
    foreach (d[i]) step(1, 1, d[i], 8'h11, 0);
    step(0, 0, 0, 8'h11, 0);
    n_checks++; if (fifo_level !== LW'(6)) begin n_err++; $display("FAIL full_level6 got %0d want 6", fifo_level); end
    step(1, 0, 0, 8'h22, 0);
    step(1, 1, 32'h5, 8'h22, 0);
    step(1, 1, 32'h6, 8'h22, 0);
    step(0, 0, 0, 8'h22, 0);
    n_checks++; if (fifo_level !== LW'(8)) begin n_err++; $display("FAIL full_level8 got %0d want 8", fifo_level); end
    step(1, 1, 32'h7, 8'h33, 0);
    step(1, 1, 32'h8, 8'h33, 0);
    n_checks++; if (dropped_events !== 16'd1) begin n_err++; $display("FAIL full_dropped got %0d want 1", dropped_events); end
    n_checks++; if (fifo_level !== LW'(8)) begin n_err++; $display("FAIL full_level_drop got %0d want 8", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy got %b want 0", busy); end
    repeat (10) step(0, 0, 0, 8'h0, 1);
    n_checks++; if (fifo_level !== '0) begin n_err++; $display("FAIL full_drained got %0d want 0", fifo_level); end
    ex = '{{2'b10, 32'hAA110000}, {2'b00, d[0]}, {2'b00, d[1]}, {2'b00, d[2]}, {2'b00, d[3]},
           {2'b01, 32'hEE000004}, {2'b10, 32'hAA220000}, {2'b01, 32'hEE800000}};
    n_checks++;
    if (got.size() !== ex.size()) begin n_err++; $display("FAIL full_len got %0d want %0d", got.size(), ex.size()); end
    else foreach (ex[i]) begin
      n_checks++; if (got[i] !== ex[i]) begin n_err++; $display("FAIL full_word%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] ex[$];
    bit rdy = 1;
    got.delete(); exp_s.delete();
    step(0, 0, 0, 8'h44, 1);
    step(1, 0, 0, 8'h44, rdy);
    for (int i = 0; i < 8; i++) begin
      rdy = ~rdy;
      if (i < 3) step(1, 1, 32'hC0 + i, 8'h44, rdy);
      else step(0, 0, 0, 8'h44, rdy);
      n_checks++;
      if (fifo_level !== LW'(m_q.size())) begin n_err++; $display("FAIL b2b_level%0d got %0d want %0d", i, fifo_level, m_q.size()); end
    end
    repeat (4) step(0, 0, 0, 8'h0, 1);
    ex = '{{2'b10, 32'hAA440000}, {2'b00, 32'hC0}, {2'b00, 32'hC1}, {2'b00, 32'hC2},
           {2'b01, 32'hEE000003}};
    n_checks++;
    if (got.size() !== ex.size()) begin n_err++; $display("FAIL b2b_len got %0d want %0d", got.size(), ex.size()); end
    else foreach (ex[i]) begin
      n_checks++; if (got[i] !== ex[i]) begin n_err++; $display("FAIL b2b_word%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 8'h50, 0);
    step(1, 0, 0, 8'h50, 0);
    step(1, 1, 32'h1, 8'h50, 0);
    step(1, 1, 32'h2, 8'h50, 0);
    trigger = 1; rst_n = 0; model_reset();
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_checks++; if (fifo_level !== '0) begin n_err++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
    @(posedge clk); #1 rst_n = 1;
    repeat (3) step(1, 1, 32'h3, 8'h50, 1);
    n_checks++; if (fifo_level !== '0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_nohdr got level %0d valid %b want 0 0", fifo_level, out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    step(0, 0, 0, 8'h55, 0);
    step(1, 0, 0, 8'h55, 0);
    n_checks++;
    if ({out_valid, out_first, out_data} !== {2'b11, 32'hAA550000}) begin
      n_err++; $display("FAIL rstmid_hdr got %b%b %h want 11 AA550000", out_valid, out_first, out_data);
    end
    step(0, 0, 0, 8'h55, 1);
    repeat (3) step(0, 0, 0, 8'h0, 1);
  endtask

  task automatic test_single();
    logic [33:0] ex[$];
    got.delete();
    step(0, 0, 0, 8'hFF, 1);
    step(1, 1, 32'h77, 8'hFF, 1);
    step(0, 1, 32'h78, 8'hFF, 1);
    repeat (3) step(0, 0, 0, 8'h0, 1);
    ex = '{{2'b10, 32'hAAFF0000}, {2'b01, 32'hEE000000}};
    n_checks++;
    if (got.size() !== ex.size()) begin n_err++; $display("FAIL single_len got %0d want %0d", got.size(), ex.size()); end
    else foreach (ex[i]) begin
      n_checks++; if (got[i] !== ex[i]) begin n_err++; $display("FAIL single_word%0d got %h want %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_random();
    bit t = 0;
    int run = 1;
    logic [7:0] ix = 8'h0;
    got.delete(); exp_s.delete();
    for (int c = 0; c < 800; c++) begin
      run--;
      if (run == 0) begin
        t = ~t; run = t ? $urandom_range(1, 12) : $urandom_range(1, 4);
        ix = 8'($urandom);
      end
      step(t, ($urandom % 4) != 0, $urandom, ix, ($urandom % 3) != 0);
      n_checks++;
      if (fifo_level !== LW'(m_q.size())) begin n_err++; $display("FAIL rand_level c%0d got %0d want %0d", c, fifo_level, m_q.size()); end
      n_checks++;
      if (dropped_events !== 16'(m_drop) || busy !== (m_mode == 1)) begin
        n_err++; $display("FAIL rand_status c%0d got drop %0d busy %b want %0d %b", c, dropped_events, busy, m_drop, m_mode == 1);
      end
    end
    repeat (20) step(0, 0, 0, 8'h0, 1);
    n_checks++;
    if (got.size() !== exp_s.size()) begin n_err++; $display("FAIL rand_len got %0d want %0d", got.size(), exp_s.size()); end
    else foreach (exp_s[i]) begin
      n_checks++; if (got[i] !== exp_s[i]) begin n_err++; $display("FAIL rand_word%0d got %h want %h", i, got[i], exp_s[i]); end
    end
  endtask

  initial begin
    trigger = 0; data_valid = 0; data_in = 0; trigger_index = 0; out_ready = 0; rst_n = 0;
    test_reset();
    test_basic();
    test_trunc();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
